// File: rtl/emulador_hcsr04_if.sv
// Purpose: bundles the sensor-side signals of the HC-SR04 emulator.
//   trigger   : trigger pulse from the measuring side
//   distancia : emulated distance in cm (unsigned)
//   echo      : emulated echo pulse
//   ocupado   : emulator busy (any state other than INICIAL)
//   pronto    : one-cycle pulse when the emulator re-arms
//   db_estado : current FSM state code
// The master modport belongs to the measuring side; the emulator uses slave.
interface emulador_hcsr04_if;
    logic       trigger;
    logic [8:0] distancia;
    logic       echo;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    modport master (
        output trigger,
        output distancia,
        input  echo,
        input  ocupado,
        input  pronto,
        input  db_estado
    );

    modport slave (
        input  trigger,
        input  distancia,
        output echo,
        output ocupado,
        output pronto,
        output db_estado
    );
endinterface

// File: rtl/emulador_hcsr04.sv
// Purpose: emulates an HC-SR04 ultrasonic sensor. A qualified trigger pulse
// starts a cycle: burst delay, echo pulse proportional to the latched
// distance, hold-off, then re-arm with a one-cycle pronto pulse.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : emulador_hcsr04_if.slave (trigger, distancia, echo, ocupado,
//           pronto, db_estado)
// Optional feature: define EMULADOR_TIMEOUT_EN to make out-of-range distances
// (0 or > DIST_MAX) produce a TIMEOUT-wide echo. Without it, distances above
// DIST_MAX saturate and distance 0 skips the echo entirely.
module emulador_hcsr04 #(
    parameter int unsigned TICKS_CM = 2941,
    parameter int unsigned TRIG_MIN = 500,
    parameter int unsigned ATRASO   = 10000,
    parameter int unsigned DIST_MAX = 400,
    parameter int unsigned TIMEOUT  = 1900000,
    parameter int unsigned HOLDOFF  = 50000
) (
    input  logic              clock,
    input  logic              reset,
    emulador_hcsr04_if.slave  bus
);

    // One shared counter width covering every cycle count the FSM needs.
    localparam int unsigned MAX_A   = (TIMEOUT > ATRASO)   ? TIMEOUT : ATRASO;
    localparam int unsigned MAX_B   = (HOLDOFF > TRIG_MIN) ? HOLDOFF : TRIG_MIN;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B)      ? MAX_A   : MAX_B;
    localparam int unsigned CNT_MAX = (MAX_C > TICKS_CM)   ? MAX_C   : TICKS_CM;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DIST_W  = 9;

    typedef enum logic [2:0] {
        INICIAL   = 3'b000,
        MEDE_TRIG = 3'b001,
        ESPERA    = 3'b010,
        ECO       = 3'b011,
        HOLD      = 3'b100
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    tick_q, tick_d;
    logic [DIST_W-1:0]   cm_q, cm_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic                trig_prev_q, trig_prev_d;
    logic                echo_q, echo_d;
    logic                ocupado_q, ocupado_d;
    logic                pronto_q, pronto_d;
`ifdef EMULADOR_TIMEOUT_EN
    logic                fora_q, fora_d;
`endif

    // State register; trigger history resets high so a held trigger is no edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= INICIAL;
            cnt_q       <= '0;
            tick_q      <= '0;
            cm_q        <= '0;
            dist_q      <= '0;
            trig_prev_q <= 1'b1;
            echo_q      <= 1'b0;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b0;
`ifdef EMULADOR_TIMEOUT_EN
            fora_q      <= 1'b0;
`endif
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            cm_q        <= cm_d;
            dist_q      <= dist_d;
            trig_prev_q <= trig_prev_d;
            echo_q      <= echo_d;
            ocupado_q   <= ocupado_d;
            pronto_q    <= pronto_d;
`ifdef EMULADOR_TIMEOUT_EN
            fora_q      <= fora_d;
`endif
        end
    end

    // Next-state and counter logic.
    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        tick_d      = tick_q;
        cm_d        = cm_q;
        dist_d      = dist_q;
        trig_prev_d = bus.trigger;
`ifdef EMULADOR_TIMEOUT_EN
        fora_d      = fora_q;
`endif
        unique case (estado_q)
            INICIAL: begin
                cnt_d = '0;
                if (bus.trigger && !trig_prev_q) begin
                    estado_d = MEDE_TRIG;
                    cnt_d    = CNT_W'(1);   // the edge cycle is the first high cycle
                end
            end
            MEDE_TRIG: begin
                if (bus.trigger) begin
                    if (cnt_q < CNT_W'(TRIG_MIN)) cnt_d = cnt_q + CNT_W'(1);
                end else if (cnt_q >= CNT_W'(TRIG_MIN)) begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
`ifdef EMULADOR_TIMEOUT_EN
                    dist_d = bus.distancia;
                    fora_d = (bus.distancia == '0) ||
                             (bus.distancia > DIST_W'(DIST_MAX));
`else
                    dist_d = (bus.distancia > DIST_W'(DIST_MAX)) ?
                             DIST_W'(DIST_MAX) : bus.distancia;
`endif
                end else begin
                    estado_d = INICIAL;
                    cnt_d    = '0;
                end
            end
            ESPERA: begin
                if (cnt_q == CNT_W'(ATRASO - 1)) begin
                    cnt_d  = '0;
                    tick_d = '0;
                    cm_d   = '0;
`ifdef EMULADOR_TIMEOUT_EN
                    estado_d = ECO;
`else
                    estado_d = (dist_q == '0) ? HOLD : ECO;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ECO: begin
`ifdef EMULADOR_TIMEOUT_EN
                if (fora_q) begin
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        estado_d = HOLD;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else
`endif
                if (tick_q == CNT_W'(TICKS_CM - 1)) begin
                    tick_d = '0;
                    cm_d   = cm_q + DIST_W'(1);
                    if (cm_d == dist_q) begin
                        estado_d = HOLD;
                        cnt_d    = '0;
                    end
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
                    estado_d = INICIAL;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                estado_d = INICIAL;
                cnt_d    = '0;
                tick_d   = '0;
                cm_d     = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        echo_d    = 1'b0;
        ocupado_d = 1'b0;
        pronto_d  = 1'b0;
        echo_d    = (estado_d == ECO);
        ocupado_d = (estado_d != INICIAL);
        pronto_d  = (estado_q == HOLD) && (estado_d == INICIAL);
    end

    assign bus.echo      = echo_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.pronto    = pronto_q;
    assign bus.db_estado = estado_q;

endmodule
